// File: rtl/fetch_wf_request_arbiter_pkg.sv
// Shared sizing and helpers for the fetch-side wavefront request arbiter.
// Sizes follow the global WF_PER_CU / WF_ID_LENGTH values.
package fetch_wf_request_arbiter_pkg;

  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;

  localparam logic [WFID_W-1:0] LAST_WF = WFID_W'(NUM_WF - 1);

  // Out-of-range ids map to an all-zero vector so they are silently ignored.
  function automatic logic [NUM_WF-1:0] wf_onehot(input logic [WFID_W-1:0] id);
    wf_onehot = '0;
    if (id <= LAST_WF) wf_onehot[id] = 1'b1;
  endfunction

endpackage

// File: rtl/fetch_wf_request_arbiter_if.sv
// Request/grant bundle between issue flow control, fetch and the arbiter.
// master = issue/fetch side driving requests and ready; slave = the arbiter.
interface fetch_wf_request_arbiter_if;
  import fetch_wf_request_arbiter_pkg::*;

  logic [NUM_WF-1:0] wave_req_bitmap;
  logic              dispatch_en;
  logic [WFID_W-1:0] dispatch_wfid;
  logic              halt_en;
  logic [WFID_W-1:0] halt_wfid;
  logic [NUM_WF-1:0] ibuf_full_bitmap;
  logic              fetch_req_ready;
  logic              fetch_req_valid;
  logic [WFID_W-1:0] fetch_req_wfid;
  logic [NUM_WF-1:0] pending_bitmap;
  logic              dup_req_err;

  modport master (
    output wave_req_bitmap, dispatch_en, dispatch_wfid, halt_en, halt_wfid,
           ibuf_full_bitmap, fetch_req_ready,
    input  fetch_req_valid, fetch_req_wfid, pending_bitmap, dup_req_err
  );

  modport slave (
    input  wave_req_bitmap, dispatch_en, dispatch_wfid, halt_en, halt_wfid,
           ibuf_full_bitmap, fetch_req_ready,
    output fetch_req_valid, fetch_req_wfid, pending_bitmap, dup_req_err
  );
endinterface

// File: rtl/fetch_wf_request_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so ptr sits at bit 0,
// take the lowest set bit, then add ptr back modulo NUM_WF.
module fetch_rr_picker
  import fetch_wf_request_arbiter_pkg::*;
(
  input  logic [NUM_WF-1:0] req,
  input  logic [WFID_W-1:0] ptr,
  output logic              found,
  output logic [WFID_W-1:0] pick
);

  logic [NUM_WF-1:0] rot;
  logic [WFID_W-1:0] off;
  logic [WFID_W:0]   sum;

  always_comb begin
    rot   = '0;
    found = 1'b0;
    off   = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      if (i + int'(ptr) >= NUM_WF) rot[i] = req[i + int'(ptr) - NUM_WF];
      else                         rot[i] = req[i + int'(ptr)];
    end
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = WFID_W'(i);
      end
    end
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum > {1'b0, LAST_WF}) pick = WFID_W'(sum - (WFID_W + 1)'(NUM_WF));
    else                       pick = sum[WFID_W-1:0];
  end

endmodule

// File: rtl/fetch_wf_request_arbiter.sv
// Latches per-WF fetch requests into pending bits and hands one eligible WF at a time
// to instruction fetch over a registered valid/ready slot, round-robin.
module fetch_wf_request_arbiter
  import fetch_wf_request_arbiter_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  fetch_wf_request_arbiter_if.slave bus
);

  logic [NUM_WF-1:0] pending_q;
  logic [NUM_WF-1:0] pending_d;
  logic [NUM_WF-1:0] set_vec;
  logic [NUM_WF-1:0] halt_vec;
  logic [NUM_WF-1:0] load_vec;
  logic [NUM_WF-1:0] eligible;
  logic              valid_q;
  logic [WFID_W-1:0] wfid_q;
  logic [WFID_W-1:0] rr_ptr_q;
  logic              err_q;
  logic              found;
  logic [WFID_W-1:0] pick;
  logic              slot_free;
  logic              load;
  logic              dup_hit;

  assign set_vec   = bus.wave_req_bitmap |
                     (bus.dispatch_en ? wf_onehot(bus.dispatch_wfid) : '0);
  assign halt_vec  = bus.halt_en ? wf_onehot(bus.halt_wfid) : '0;
  assign eligible  = pending_q & ~bus.ibuf_full_bitmap;
  assign slot_free = ~valid_q | bus.fetch_req_ready;
  assign load      = slot_free & found;
  assign load_vec  = load ? wf_onehot(pick) : '0;

  // Halt wins over a same-cycle set; a set wins over the load-clear of the same WF.
  assign pending_d = ~halt_vec & (set_vec | (pending_q & ~load_vec));

  assign dup_hit = (|(set_vec & pending_q)) |
                   (valid_q & ~bus.fetch_req_ready & set_vec[wfid_q]);

  fetch_rr_picker u_picker (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .found (found),
    .pick  (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      wfid_q    <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (slot_free) begin
        valid_q <= found;
        if (found) begin
          wfid_q   <= pick;
          rr_ptr_q <= (pick == LAST_WF) ? '0 : pick + 1'b1;
        end
      end
      if (dup_hit) err_q <= 1'b1;
    end
  end

  assign bus.fetch_req_valid = valid_q;
  assign bus.fetch_req_wfid  = wfid_q;
  assign bus.pending_bitmap  = pending_q;
  assign bus.dup_req_err     = err_q;

endmodule

// File: tb/tb_fetch_wf_request_arbiter.sv
// Self-checking bench for fetch_wf_request_arbiter: grant scoreboard plus a vector
// table for round-robin ordering and hand-timed sequences for the corner cases.
module tb_fetch_wf_request_arbiter;
  import fetch_wf_request_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_wf_request_arbiter_if bus ();

  fetch_wf_request_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int sb[$];

  typedef struct {
    bit                do_reset;
    logic [NUM_WF-1:0] req;
    int                n;
    int                exp[3];
  } vec_t;

  vec_t vecs[4];

  function automatic logic [NUM_WF-1:0] bit_of(input int k);
    bit_of    = '0;
    bit_of[k] = 1'b1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit rdy);
    tick();
    rst                  = 1'b1;
    bus.wave_req_bitmap  = '0;
    bus.dispatch_en      = 1'b0;
    bus.halt_en          = 1'b0;
    bus.ibuf_full_bitmap = '0;
    bus.fetch_req_ready  = rdy;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.fetch_req_valid) break;
    end
    check("drain_outstanding", 64'(sb.size()), 64'(0));
  endtask

  task automatic chk_slot(input string name, input bit v, input int id);
    check({name, "_valid"}, 64'(bus.fetch_req_valid), 64'(v));
    if (v) check({name, "_wfid"}, 64'(bus.fetch_req_wfid), 64'(id));
  endtask

  // Every completed handshake must match the next expected grant.
  always @(negedge clk) begin
    if (!rst && bus.fetch_req_valid && bus.fetch_req_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_grant: got wfid %0d, expected no grant", bus.fetch_req_wfid);
      end else begin
        check("grant_order", 64'(bus.fetch_req_wfid), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wave_req_bitmap  = '0;
    bus.dispatch_en      = 1'b0;
    bus.dispatch_wfid    = '0;
    bus.halt_en          = 1'b0;
    bus.halt_wfid        = '0;
    bus.ibuf_full_bitmap = '0;
    bus.fetch_req_ready  = 1'b1;

    vecs[0].do_reset = 1'b1; vecs[0].req = bit_of(3) | bit_of(7) | bit_of(39);
    vecs[0].n = 3; vecs[0].exp[0] = 3;  vecs[0].exp[1] = 7; vecs[0].exp[2] = 39;
    vecs[1].do_reset = 1'b0; vecs[1].req = bit_of(0) | bit_of(4);
    vecs[1].n = 2; vecs[1].exp[0] = 0;  vecs[1].exp[1] = 4; vecs[1].exp[2] = 0;
    vecs[2].do_reset = 1'b0; vecs[2].req = bit_of(1) | bit_of(38);
    vecs[2].n = 2; vecs[2].exp[0] = 38; vecs[2].exp[1] = 1; vecs[2].exp[2] = 0;
    vecs[3].do_reset = 1'b0; vecs[3].req = bit_of(20);
    vecs[3].n = 1; vecs[3].exp[0] = 20; vecs[3].exp[1] = 0; vecs[3].exp[2] = 0;

    // Reset state and single-request latency
    do_reset(1'b1);
    @(negedge clk);
    check("rst_valid",   64'(bus.fetch_req_valid), 64'(0));
    check("rst_wfid",    64'(bus.fetch_req_wfid),  64'(0));
    check("rst_pending", 64'(bus.pending_bitmap),  64'(0));
    check("rst_err",     64'(bus.dup_req_err),     64'(0));
    tick(); bus.wave_req_bitmap = bit_of(5); sb.push_back(5);
    tick(); bus.wave_req_bitmap = '0;
    @(negedge clk);
    check("t1_pending_c1", 64'(bus.pending_bitmap), 64'(bit_of(5)));
    chk_slot("t1_c1", 1'b0, 0);
    tick(); @(negedge clk); chk_slot("t1_c2", 1'b1, 5);
    tick(); @(negedge clk); chk_slot("t1_c3", 1'b0, 0);
    check("t1_pending_c3", 64'(bus.pending_bitmap), 64'(0));

    // Round-robin ordering vectors
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].do_reset) do_reset(1'b1);
      bus.fetch_req_ready = 1'b1;
      tick();
      bus.wave_req_bitmap = vecs[v].req;
      for (int e = 0; e < vecs[v].n; e++) sb.push_back(vecs[v].exp[e]);
      tick();
      bus.wave_req_bitmap = '0;
      drain(30);
      check("vec_pending_empty", 64'(bus.pending_bitmap), 64'(0));
    end

    // Backpressure: held request stays stable, later request follows right after ready
    bus.fetch_req_ready = 1'b0;
    tick(); bus.wave_req_bitmap = bit_of(9); sb.push_back(9);
    tick(); bus.wave_req_bitmap = '0;
    for (int c = 2; c < 6; c++) begin
      tick();
      if (c == 3) begin
        bus.wave_req_bitmap = bit_of(12);
        sb.push_back(12);
      end else begin
        bus.wave_req_bitmap = '0;
      end
      @(negedge clk);
      chk_slot("t3_hold", 1'b1, 9);
    end
    tick(); bus.wave_req_bitmap = '0; bus.fetch_req_ready = 1'b1;
    @(negedge clk); chk_slot("t3_c6", 1'b1, 9);
    tick(); @(negedge clk); chk_slot("t3_c7", 1'b1, 12);
    drain(20);

    // Full instruction buffer masks a pending WF until it drains
    tick(); bus.ibuf_full_bitmap = bit_of(2); bus.wave_req_bitmap = bit_of(2) | bit_of(6);
    sb.push_back(6);
    tick(); bus.wave_req_bitmap = '0;
    tick(); @(negedge clk); chk_slot("t4_c2", 1'b1, 6);
    tick(); @(negedge clk); chk_slot("t4_c3", 1'b0, 0);
    check("t4_pending_c3", 64'(bus.pending_bitmap), 64'(bit_of(2)));
    tick(); bus.ibuf_full_bitmap = '0; sb.push_back(2);
    @(negedge clk); chk_slot("t4_c4", 1'b0, 0);
    tick(); @(negedge clk); chk_slot("t4_c5", 1'b1, 2);
    drain(20);

    // Halt beats same-cycle request; out-of-range dispatch ignored; dispatch latency
    tick(); bus.wave_req_bitmap = bit_of(4); bus.halt_en = 1'b1; bus.halt_wfid = 6'd4;
    tick(); bus.wave_req_bitmap = '0; bus.halt_en = 1'b0;
    @(negedge clk); check("t5_pending_halt", 64'(bus.pending_bitmap), 64'(0));
    tick(); @(negedge clk); chk_slot("t5_c2", 1'b0, 0);
    tick(); bus.dispatch_en = 1'b1; bus.dispatch_wfid = 6'd45;
    tick(); bus.dispatch_en = 1'b0;
    @(negedge clk); check("t5_pending_oor", 64'(bus.pending_bitmap), 64'(0));
    tick(); bus.dispatch_en = 1'b1; bus.dispatch_wfid = 6'd4; sb.push_back(4);
    tick(); bus.dispatch_en = 1'b0;
    @(negedge clk); check("t5_pending_disp", 64'(bus.pending_bitmap), 64'(bit_of(4)));
    chk_slot("t5_c6", 1'b0, 0);
    tick(); @(negedge clk); chk_slot("t5_c7", 1'b1, 4);
    drain(20);
    check("t5_err_clear", 64'(bus.dup_req_err), 64'(0));

    // Duplicate request: sticky error, single grant, cleared by reset
    bus.fetch_req_ready = 1'b0;
    tick(); bus.wave_req_bitmap = bit_of(1); sb.push_back(1);
    tick(); bus.wave_req_bitmap = '0;
    tick(); @(negedge clk); chk_slot("t6_c2", 1'b1, 1);
    tick(); bus.wave_req_bitmap = bit_of(8); sb.push_back(8);
    tick(); bus.wave_req_bitmap = '0;
    @(negedge clk); check("t6_err_first", 64'(bus.dup_req_err), 64'(0));
    tick(); bus.wave_req_bitmap = bit_of(8);
    tick(); bus.wave_req_bitmap = '0;
    @(negedge clk); check("t6_err_set", 64'(bus.dup_req_err), 64'(1));
    check("t6_pending_merge", 64'(bus.pending_bitmap), 64'(bit_of(8)));
    tick(); bus.fetch_req_ready = 1'b1;
    @(negedge clk); chk_slot("t6_c7", 1'b1, 1);
    tick(); @(negedge clk); chk_slot("t6_c8", 1'b1, 8);
    drain(20);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", 64'(bus.dup_req_err), 64'(1));
    do_reset(1'b1);
    @(negedge clk); check("t6_err_rst", 64'(bus.dup_req_err), 64'(0));

    // Reset during a stalled handshake discards the held request
    bus.fetch_req_ready = 1'b0;
    tick(); bus.wave_req_bitmap = bit_of(11);
    tick(); bus.wave_req_bitmap = '0;
    tick(); @(negedge clk); chk_slot("t7_held", 1'b1, 11);
    tick(); rst = 1'b1; bus.fetch_req_ready = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("t7_valid", 64'(bus.fetch_req_valid), 64'(0));
    check("t7_wfid",  64'(bus.fetch_req_wfid),  64'(0));
    check("t7_pend",  64'(bus.pending_bitmap),  64'(0));

    // Everything pending, everything full: nothing issues until buffers free up
    tick(); bus.ibuf_full_bitmap = '1; bus.wave_req_bitmap = '1;
    tick(); bus.wave_req_bitmap = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t8_valid_blocked", 64'(bus.fetch_req_valid), 64'(0));
      check("t8_pending_all", 64'(bus.pending_bitmap), 64'({NUM_WF{1'b1}}));
    end
    tick(); bus.ibuf_full_bitmap = '0;
    for (int w = 0; w < NUM_WF; w++) sb.push_back(w);
    drain(NUM_WF + 10);
    check("t8_pending_empty", 64'(bus.pending_bitmap), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
